// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared definitions for the MIPS load/store unit. Holds the
//               load/store opcode encodings, the LSU state type, the
//               access-size type and small opcode decode helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Primary opcode field (instr[31:26]) encodings
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [5:0] OP_LUI = 6'h0F;

    typedef enum logic [1:0] {
        LSU_IDLE   = 2'd0,
        LSU_ACCESS = 2'd1,
        LSU_DONE   = 2'd2
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } lsu_size_t;

    // Any opcode not recognised as a byte or half access is treated as a word.
    function automatic lsu_size_t lsu_size(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: return SZ_HALF;
            default:              return SZ_WORD;
        endcase
    endfunction

    // Only lb and lh sign-extend; everything else zero-extends or is a word.
    function automatic logic lsu_signed(input logic [5:0] op);
        return (op == OP_LB) || (op == OP_LH);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_lsu_lane.sv
`default_nettype none
// ============================================================================
// Module      : mips_lsu_lane
// Description : Purely combinational byte-lane logic for the load/store unit.
//               Generates little-endian byte enables, replicates store data
//               across lanes and extracts/extends the selected load lane.
// Ports       : i_opcode     - captured load/store opcode (size and sign)
//               i_addr_lo    - captured address bits [1:0]
//               i_wdata      - captured store data
//               i_rdata_word - word returned by memory
//               o_be         - byte enables for the access
//               o_wdata      - lane-replicated store data
//               o_load_data  - extended load result
// Revision    : 1.0 - initial release
// ============================================================================
module mips_lsu_lane
    import mips_pkg::*;
(
    input  logic [5:0]  i_opcode,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rdata_word,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic        w_sign;
    lsu_size_t   w_size;

    always_comb begin
        w_size      = lsu_size(i_opcode);
        w_sign      = lsu_signed(i_opcode);
        w_byte      = i_rdata_word[{i_addr_lo, 3'b000} +: 8];
        w_half      = i_addr_lo[1] ? i_rdata_word[31:16] : i_rdata_word[15:0];
        o_be        = 4'b1111;
        o_wdata     = i_wdata;
        o_load_data = i_rdata_word;

        case (w_size)
            SZ_BYTE: begin
                o_be        = 4'b0001 << i_addr_lo;
                o_wdata     = {4{i_wdata[7:0]}};
                o_load_data = w_sign ? {{24{w_byte[7]}}, w_byte}
                                     : {24'h000000, w_byte};
            end
            SZ_HALF: begin
                // addr[0] plays no part in lane selection for halfwords
                o_be        = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata     = {2{i_wdata[15:0]}};
                o_load_data = w_sign ? {{16{w_half[15]}}, w_half}
                                     : {16'h0000, w_half};
            end
            default: begin
                o_be        = 4'b1111;
                o_wdata     = i_wdata;
                o_load_data = i_rdata_word;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mips_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : mips_load_store_unit
// Description : Load/store unit between the MIPS pipeline and a simple
//               request/acknowledge memory bus. Three-state FSM
//               (IDLE -> ACCESS -> DONE) with a bounded wait for bus_ack.
// Parameters  : TIMEOUT_CYCLES - ACCESS cycles allowed before abort
// Macro       : MIPS_LSU_ALIGN_CHECK_EN - when defined, adds the misaligned
//               output and rejects misaligned half/word accesses without
//               touching the bus.
// Ports       : clk, reset           - clock, synchronous active-high reset
//               MemRead, MemWrite    - load / store command (IDLE only)
//               opcode, addr, wdata  - access descriptor
//               rdata                - extended load result (held)
//               busy, done, timeout  - pipeline stall / completion status
//               bus_*                - memory-side request / response
//               misaligned           - alignment fault (macro only)
// Revision    : 1.0 - initial release
// ============================================================================
module mips_load_store_unit
    import mips_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [5:0]  opcode,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata,
`ifdef MIPS_LSU_ALIGN_CHECK_EN
    output logic        misaligned,
`endif
    output logic        timeout
);

    // Counter runs 0 .. TIMEOUT_CYCLES-1, one count per ACCESS cycle
    localparam int c_WAIT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t          r_state;
    lsu_state_t          w_next_state;
    logic                r_is_store;
    logic [5:0]          r_opcode;
    logic [31:0]         r_addr;
    logic [31:0]         r_wdata;
    logic [31:0]         r_rdata;
    logic [c_WAIT_W-1:0] r_wait;
    logic                r_timeout;
    logic                w_cmd;
    logic                w_in_access;
    logic                w_wait_expired;
    logic                w_misalign_cmd;
    logic [3:0]          w_be;
    logic [31:0]         w_store_data;
    logic [31:0]         w_load_data;

    assign w_cmd          = MemRead | MemWrite;
    assign w_in_access    = (r_state == LSU_ACCESS);
    assign w_wait_expired = (r_wait == c_WAIT_LAST);

`ifdef MIPS_LSU_ALIGN_CHECK_EN
    logic      r_misaligned;
    lsu_size_t w_cmd_size;

    assign w_cmd_size     = lsu_size(opcode);
    assign w_misalign_cmd = ((w_cmd_size == SZ_HALF) && addr[0]) ||
                            ((w_cmd_size == SZ_WORD) && (addr[1:0] != 2'b00));
    assign misaligned     = r_misaligned;
`else
    assign w_misalign_cmd = 1'b0;
`endif

    mips_lsu_lane u_lane (
        .i_opcode     (r_opcode),
        .i_addr_lo    (r_addr[1:0]),
        .i_wdata      (r_wdata),
        .i_rdata_word (bus_rdata),
        .o_be         (w_be),
        .o_wdata      (w_store_data),
        .o_load_data  (w_load_data)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= LSU_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            LSU_IDLE: begin
                if (w_cmd) begin
                    // A misaligned access completes without ever requesting the bus
                    w_next_state = w_misalign_cmd ? LSU_DONE : LSU_ACCESS;
                end
            end
            LSU_ACCESS: begin
                if (bus_ack || w_wait_expired) begin
                    w_next_state = LSU_DONE;
                end
            end
            LSU_DONE: begin
                w_next_state = LSU_IDLE;
            end
            default: begin
                w_next_state = LSU_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Command capture, wait counter and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_is_store   <= 1'b0;
            r_opcode     <= 6'd0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_rdata      <= 32'd0;
            r_wait       <= '0;
            r_timeout    <= 1'b0;
`ifdef MIPS_LSU_ALIGN_CHECK_EN
            r_misaligned <= 1'b0;
`endif
        end else begin
            case (r_state)
                LSU_IDLE: begin
                    if (w_cmd) begin
                        // MemWrite wins when both commands are raised together
                        r_is_store   <= MemWrite;
                        r_opcode     <= opcode;
                        r_addr       <= addr;
                        r_wdata      <= wdata;
                        r_wait       <= '0;
`ifdef MIPS_LSU_ALIGN_CHECK_EN
                        r_misaligned <= w_misalign_cmd;
`endif
                    end
                end
                LSU_ACCESS: begin
                    if (bus_ack) begin
                        if (!r_is_store) begin
                            r_rdata <= w_load_data;
                        end
                    end else if (w_wait_expired) begin
                        r_timeout <= 1'b1;
                        if (!r_is_store) begin
                            r_rdata <= 32'd0;
                        end
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                LSU_DONE: begin
                    r_wait       <= '0;
                    r_timeout    <= 1'b0;
`ifdef MIPS_LSU_ALIGN_CHECK_EN
                    r_misaligned <= 1'b0;
`endif
                end
                default: begin
                    r_wait <= '0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: bus fields are forced to zero outside ACCESS so the bus is
    // quiet whenever no request is active.
    // ------------------------------------------------------------------
    assign busy      = w_in_access;
    assign done      = (r_state == LSU_DONE);
    assign timeout   = r_timeout;
    assign rdata     = r_rdata;
    assign bus_req   = w_in_access;
    assign bus_we    = w_in_access & r_is_store;
    assign bus_addr  = w_in_access ? {r_addr[31:2], 2'b00} : 32'd0;
    assign bus_be    = w_in_access ? w_be : 4'b0000;
    assign bus_wdata = w_in_access ? w_store_data : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_mips_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_load_store_unit
// Description : Self-checking bench for mips_load_store_unit. Directed
//               stimulus pushes expected completions into a scoreboard
//               queue; a monitor pops and compares on every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_load_store_unit;
    import mips_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemRead, MemWrite;
    logic [5:0]  opcode;
    logic [31:0] addr, wdata, rdata;
    logic        busy, done, bus_req, bus_we, bus_ack, timeout;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;
`ifdef MIPS_LSU_ALIGN_CHECK_EN
    logic        misaligned;
`endif

    typedef struct packed {
        logic [31:0] rdata;
        logic        timeout;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mips_load_store_unit #(.TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .opcode     (opcode),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .busy       (busy),
        .done       (done),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata),
`ifdef MIPS_LSU_ALIGN_CHECK_EN
        .misaligned (misaligned),
`endif
        .timeout    (timeout)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_done(input logic [31:0] r, input logic t);
        exp_t e;
        e.rdata   = r;
        e.timeout = t;
        sb_q.push_back(e);
    endtask

    // Monitor: every done pulse must match the oldest expected completion
    always @(negedge clk) begin : mon
        exp_t e;
        if (!reset && done) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no completion");
            end else begin
                e = sb_q.pop_front();
                check("done_rdata", rdata, e.rdata);
                check("done_timeout", 32'(timeout), 32'(e.timeout));
            end
        end
    end

    // Waits one cycle (so the FSM is in IDLE), then presents a command for one cycle
    task automatic issue(input logic rd, input logic wr, input logic [5:0] op,
                         input logic [31:0] a, input logic [31:0] wd);
        @(posedge clk); #1;
        MemRead = rd; MemWrite = wr; opcode = op; addr = a; wdata = wd;
        check("idle_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        MemRead = 1'b0; MemWrite = 1'b0;
    endtask

    // Memory responder: holds ack low for 'waits' ACCESS cycles, then acks
    task automatic serve(input int waits, input logic [31:0] rd,
                         input logic [31:0] e_addr, input logic [3:0] e_be,
                         input logic e_we, input logic [31:0] e_wd,
                         input bit chk_wd, input bit poke);
        for (int i = 0; i <= waits; i++) begin
            check("bus_req", 32'(bus_req), 32'd1);
            check("access_busy", 32'(busy), 32'd1);
            check("bus_addr", bus_addr, e_addr);
            check("bus_be", 32'(bus_be), 32'(e_be));
            check("bus_we", 32'(bus_we), 32'(e_we));
            if (chk_wd) check("bus_wdata", bus_wdata, e_wd);
            // A command raised while busy must be dropped, not queued
            if (poke && i == 1) begin
                MemRead = 1'b1; opcode = OP_LW;
            end else begin
                MemRead = 1'b0;
            end
            if (i == waits) begin
                bus_ack = 1'b1; bus_rdata = rd;
            end
            @(posedge clk); #1;
            bus_ack = 1'b0;
        end
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("done_req", 32'(bus_req), 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000");
        $fatal(1, "bench timeout");
    end

    initial begin : stim
        int n;
        reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; opcode = 6'd0;
        addr = 32'd0; wdata = 32'd0; bus_ack = 1'b0; bus_rdata = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_req", 32'(bus_req), 32'd0);
        check("rst_we", 32'(bus_we), 32'd0);
        check("rst_be", 32'(bus_be), 32'd0);
        check("rst_addr", bus_addr, 32'd0);
        check("rst_wdata", bus_wdata, 32'd0);
        check("rst_rdata", rdata, 32'd0);
`ifdef MIPS_LSU_ALIGN_CHECK_EN
        check("rst_misaligned", 32'(misaligned), 32'd0);
`endif
        reset = 1'b0;

        // lw, ack in the first ACCESS cycle: done two cycles after the command
        expect_done(32'hDEADBEEF, 1'b0);
        issue(1, 0, OP_LW, 32'h100, 32'h0);
        serve(0, 32'hDEADBEEF, 32'h100, 4'b1111, 1'b0, 32'h0, 0, 0);

        // lb / lbu on the top lane of a negative byte
        expect_done(32'hFFFFFF80, 1'b0);
        issue(1, 0, OP_LB, 32'h103, 32'h0);
        serve(0, 32'h80123456, 32'h100, 4'b1000, 1'b0, 32'h0, 0, 0);
        expect_done(32'h00000080, 1'b0);
        issue(1, 0, OP_LBU, 32'h103, 32'h0);
        serve(0, 32'h80123456, 32'h100, 4'b1000, 1'b0, 32'h0, 0, 0);

        // lh upper half (sign-extended), lhu lower half (zero-extended)
        expect_done(32'hFFFF8012, 1'b0);
        issue(1, 0, OP_LH, 32'h102, 32'h0);
        serve(0, 32'h80123456, 32'h100, 4'b1100, 1'b0, 32'h0, 0, 0);
        expect_done(32'h0000F00D, 1'b0);
        issue(1, 0, OP_LHU, 32'h100, 32'h0);
        serve(1, 32'h1234F00D, 32'h100, 4'b0011, 1'b0, 32'h0, 0, 0);

        // sh with 3 wait cycles and a stray command mid-access; rdata untouched
        expect_done(32'h0000F00D, 1'b0);
        issue(0, 1, OP_SH, 32'h202, 32'h0000ABCD);
        serve(3, 32'h55555555, 32'h200, 4'b1100, 1'b1, 32'hABCDABCD, 1, 1);

        // sb and sw lane replication
        expect_done(32'h0000F00D, 1'b0);
        issue(0, 1, OP_SB, 32'h201, 32'h000000A5);
        serve(0, 32'h0, 32'h200, 4'b0010, 1'b1, 32'hA5A5A5A5, 1, 0);
        expect_done(32'h0000F00D, 1'b0);
        issue(0, 1, OP_SW, 32'h300, 32'h12345678);
        serve(2, 32'h0, 32'h300, 4'b1111, 1'b1, 32'h12345678, 1, 0);

        // Unlisted opcode with MemRead behaves as lw
        expect_done(32'hCAFEF00D, 1'b0);
        issue(1, 0, OP_LUI, 32'h104, 32'h0);
        serve(0, 32'hCAFEF00D, 32'h104, 4'b1111, 1'b0, 32'h0, 0, 0);

        // bus_ack while idle has no effect
        @(posedge clk); #1;
        bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
        repeat (2) @(posedge clk);
        #1;
        bus_ack = 1'b0;
        check("stray_ack_done", 32'(done), 32'd0);
        check("stray_ack_rdata", rdata, 32'hCAFEF00D);

        // Misaligned lw
`ifdef MIPS_LSU_ALIGN_CHECK_EN
        expect_done(32'hCAFEF00D, 1'b0);
        issue(1, 0, OP_LW, 32'h101, 32'h0);
        check("mis_req", 32'(bus_req), 32'd0);
        check("mis_done", 32'(done), 32'd1);
        check("mis_flag", 32'(misaligned), 32'd1);
`else
        expect_done(32'h0BADF00D, 1'b0);
        issue(1, 0, OP_LW, 32'h101, 32'h0);
        serve(0, 32'h0BADF00D, 32'h100, 4'b1111, 1'b0, 32'h0, 0, 0);
`endif

        // lw with no ack: 16 request cycles then abort with timeout and rdata=0
        expect_done(32'h0, 1'b1);
        issue(1, 0, OP_LW, 32'h500, 32'h0);
        n = 0;
        while (bus_req && n < 40) begin
            n++;
            @(posedge clk); #1;
        end
        check("timeout_req_cycles", 32'(n), 32'd16);
        check("timeout_done", 32'(done), 32'd1);
        check("timeout_flag", 32'(timeout), 32'd1);

        // Load something nonzero, then reset in the middle of another access
        expect_done(32'h13579BDF, 1'b0);
        issue(1, 0, OP_LW, 32'h600, 32'h0);
        serve(0, 32'h13579BDF, 32'h600, 4'b1111, 1'b0, 32'h0, 0, 0);
        issue(1, 0, OP_LW, 32'h700, 32'h0);
        check("pre_reset_req", 32'(bus_req), 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("post_reset_req", 32'(bus_req), 32'd0);
        check("post_reset_busy", 32'(busy), 32'd0);
        check("post_reset_rdata", rdata, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("post_reset_no_done", 32'(done), 32'd0);

        // MemRead and MemWrite together: the store wins, rdata unchanged
        expect_done(32'h0, 1'b0);
        issue(1, 1, OP_LW, 32'h800, 32'h11223344);
        serve(0, 32'hFFFFFFFF, 32'h800, 4'b1111, 1'b1, 32'h11223344, 1, 0);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
